// File: rtl/cgra_config_pkg.sv
// ============================================================================
// Module      : cgra_config (package)
// Description : Shared FSM encoding and default sizes for the CGRA config loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cgra_config;

    localparam int CFG_CHAIN_LEN = 64;
    localparam int CFG_WORD_W    = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } cfg_state_t;

endpackage

`default_nettype wire

// File: rtl/config_loader.sv
// ============================================================================
// Module      : config_loader
// Description : Streams bitstream words MSB-first into a serial config chain,
//               capturing the chain tail into a readback word as it shifts.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module config_loader
    import cgra_config::*;
#(
    parameter int CHAIN_LEN = CFG_CHAIN_LEN,
    parameter int WORD_W    = CFG_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_first,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              config_in,
    output logic              config_shift,
    output logic              config_reset,
    input  logic              config_out,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_word
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WC_W  = $clog2(WORD_W);

    cfg_state_t        r_state;
    cfg_state_t        w_next_state;
    logic [WORD_W-1:0] r_sreg;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WC_W-1:0]   r_word_cnt;
    logic [WORD_W-1:0] r_rb;

    logic w_last_bit;
    logic w_last_of_word;

    // Chain length takes priority: a short final word ends the load early.
    assign w_last_bit     = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_last_of_word = (r_word_cnt == WC_W'(WORD_W - 1));
    assign rb_word        = r_rb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        cfg_ready    = 1'b0;
        config_in    = 1'b0;
        config_shift = 1'b0;
        config_reset = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = clear_first ? CLEAR : LOAD;
                end
            end
            CLEAR: begin
                config_reset = 1'b1;
                busy         = 1'b1;
                w_next_state = LOAD;
            end
            LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (cfg_valid) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                config_shift = 1'b1;
                config_in    = r_sreg[WORD_W-1];
                busy         = 1'b1;
                if (w_last_bit) begin
                    w_next_state = DONE;
                end else if (w_last_of_word) begin
                    w_next_state = LOAD;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sreg     <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_rb       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        r_sreg     <= cfg_data;
                        r_word_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_sreg     <= {r_sreg[WORD_W-2:0], 1'b0};
                    r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                    r_word_cnt <= r_word_cnt + WC_W'(1);
                    r_rb       <= {r_rb[WORD_W-2:0], config_out};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 64, meaning the total number of config_cell bits in the downstream chain (legal range 1..4096).
REQ-002 The block SHALL have parameter WORD_W, default 32, meaning the bitstream word width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state advances on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle load request.
REQ-006 The block SHALL have port clear_first, input, 1 bit: sampled with start; when high, the chain is cleared before shifting.
REQ-007 The block SHALL have port cfg_data, input, WORD_W bits: a bitstream word, MSB shifted first.
REQ-008 The block SHALL have ports cfg_valid (input, 1 bit) and cfg_ready (output, 1 bit): the word handshake.
REQ-009 The block SHALL have port config_in, output, 1 bit: the serial bit to the chain head.
REQ-010 The block SHALL have port config_shift, output, 1 bit: the chain shift enable, exactly one chain bit per high cycle.
REQ-011 The block SHALL have port config_reset, output, 1 bit: the active-high chain clear.
REQ-012 The block SHALL have port config_out, input, 1 bit: the serial bit returning from the chain tail.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a load is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-015 The block SHALL have port rb_word, output, WORD_W bits: the last WORD_W bits captured from config_out.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, LOAD, SHIFT and DONE.
REQ-017 In IDLE, start=1 SHALL register clear_first and go to CLEAR if clear_first=1, otherwise to LOAD. start SHALL be ignored in every other state.
REQ-018 CLEAR SHALL last exactly 1 cycle with config_reset=1, then go to LOAD. config_reset SHALL be 0 in all other states.
REQ-019 In LOAD, cfg_ready SHALL be 1. On cfg_valid&cfg_ready the block SHALL capture cfg_data into the shift register and go to SHIFT. cfg_ready SHALL be 0 in all other states.
REQ-020 In SHIFT, config_shift SHALL be 1 and config_in SHALL be the shift-register MSB. The register SHALL shift left by 1, and the bit counter (width clog2(CHAIN_LEN+1)) SHALL increment each cycle.
REQ-021 In SHIFT, config_out SHALL be sampled each cycle into rb_word: rb_word <= {rb_word[WORD_W-2:0], config_out}.
REQ-022 When the bit counter reaches CHAIN_LEN, the FSM SHALL go to DONE. Otherwise, once WORD_W bits of the current word have shifted, it SHALL go to LOAD (one bubble cycle is allowed per word).
REQ-023 Words consumed SHALL equal ceil(CHAIN_LEN/WORD_W). The unused LSBs of the final word SHALL be discarded.
REQ-024 DONE SHALL assert done=1 for 1 cycle, then go to IDLE.
REQ-025 busy SHALL be 1 in CLEAR, LOAD and SHIFT, and 0 in IDLE and DONE.
REQ-026 In LOAD with cfg_valid=0, the block SHALL stall with config_shift=0 and no bit lost. There is no timeout.
REQ-027 config_shift SHALL never be 1 in the same cycle as config_reset.
REQ-028 rb_word SHALL hold its value from IDLE until the next SHIFT cycle.

Reset
REQ-029 While reset=0, the block SHALL asynchronously force state=IDLE, and the counters, shift register and rb_word to 0.
REQ-030 While reset=0, the block SHALL force cfg_ready, config_in, config_shift, config_reset, busy and done to 0.
REQ-031 Reset asserted mid-load SHALL abandon the load with no done pulse. The chain is left partially shifted; software restarts with clear_first=1.

Structure
REQ-032 The FSM state enumeration and the default CHAIN_LEN/WORD_W constants SHALL live in the shared cgra_config package.
REQ-033 The block SHALL be a single module with no sub-modules. The optional serialiser split SHALL be named config_serializer if used.

Verification
REQ-034 Scenario (CHAIN_LEN=40, clear_first=1, words 0xA5000000 then 0xFF000000 offered immediately): config_reset for 1 cycle -> 40 config_shift pulses; config_in = 10100101 followed by 24 zeros, then 8 ones; done 1 cycle; 2 handshakes.
REQ-035 Scenario (CHAIN_LEN=64, loopback chain of 64 flops preloaded with 0x12345678_9ABCDEF0, clear_first=0): rb_word=0x9ABCDEF0 after done.
REQ-036 Scenario (cfg_valid held low 10 cycles in LOAD): cfg_ready stays 1, config_shift stays 0, the bit count is unchanged, and the load then resumes correctly.
REQ-037 Scenario (start pulsed during SHIFT): no effect, exactly one done pulse.
REQ-038 Scenario (reset=0 after 20 shifted bits): all outputs 0 immediately with no clock, state IDLE; a new start with clear_first=1 produces a full correct load.
REQ-039 Scenario (CHAIN_LEN=1, word 0x80000000): 1 config_shift cycle with config_in=1, then done.
